// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller_if
// Description : Controller <-> datapath bundle for the multicycle controller.
//               MemReady exists only when MC_MEMRDY_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface mc_controller_if #(
    parameter int ALUCTRL_W = 2
);
    logic [31:12]          Instr;
    logic [3:0]            ALUFlags;
`ifdef MC_MEMRDY_EN
    logic                  MemReady;
`endif
    logic                  PCWrite;
    logic                  IRWrite;
    logic                  RegWrite;
    logic                  MemWrite;
    logic                  AdrSrc;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [1:0]            ResultSrc;
    logic [1:0]            ImmSrc;
    logic [1:0]            RegSrc;
    logic [ALUCTRL_W-1:0]  ALUControl;
    logic [3:0]            State;

`ifdef MC_MEMRDY_EN
    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
    );
    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
    );
`else
    modport master (
        input  Instr, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
    );
    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle ARM-subset controller FSM with conditional
//               execution and flag register. MC_MEMRDY_EN adds memory stalls.
// Revision    : 1.0  initial release
// ============================================================================
module mc_controller #(
    parameter int ALUCTRL_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);
    localparam logic [3:0] c_fetch    = 4'd0;
    localparam logic [3:0] c_decode   = 4'd1;
    localparam logic [3:0] c_memadr   = 4'd2;
    localparam logic [3:0] c_memread  = 4'd3;
    localparam logic [3:0] c_memwb    = 4'd4;
    localparam logic [3:0] c_memwrite = 4'd5;
    localparam logic [3:0] c_execr    = 4'd6;
    localparam logic [3:0] c_execi    = 4'd7;
    localparam logic [3:0] c_aluwb    = 4'd8;
    localparam logic [3:0] c_branch   = 4'd9;
    localparam logic [3:0] c_undef    = 4'd10;

    localparam logic [2:0]           c_op_eor3 = 3'd4;
    localparam logic [ALUCTRL_W-1:0] c_op_add  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] c_op_sub  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] c_op_and  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] c_op_orr  = ALUCTRL_W'(3);
    // EOR only exists with a 3-bit ALU control; narrower builds fall back to ADD
    localparam logic [ALUCTRL_W-1:0] c_op_eor  =
        (ALUCTRL_W == 3) ? c_op_eor3[ALUCTRL_W-1:0] : c_op_add;

    logic [3:0]           r_state;
    logic [3:0]           r_flags;
    logic                 r_cond_ex;

    logic [3:0]           w_next;
    logic                 w_cond_ex;
    logic                 w_mem_ready;
    logic [ALUCTRL_W-1:0] w_dp_op;
    logic                 w_rd_pc;
    logic                 w_unused_rn;

    logic [3:0]           w_cond;
    logic [1:0]           w_op;
    logic [5:0]           w_funct;

    logic                 w_pc_write, w_ir_write, w_reg_write, w_mem_write;
    logic                 w_adr_src, w_alu_src_a;
    logic [1:0]           w_alu_src_b, w_result_src;
    logic [ALUCTRL_W-1:0] w_alu_ctrl;
    logic [3:0]           w_state_out;

    assign w_cond      = bus.Instr[31:28];
    assign w_op        = bus.Instr[27:26];
    assign w_funct     = bus.Instr[25:20];
    assign w_rd_pc     = (bus.Instr[15:12] == 4'hF);
    assign w_unused_rn = ^bus.Instr[19:16];

`ifdef MC_MEMRDY_EN
    assign w_mem_ready = bus.MemReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    // Condition check against the architectural flags {N,Z,C,V}
    always_comb begin
        w_cond_ex = 1'b1;
        case (w_cond)
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = ~r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = ~r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = ~r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = ~r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
            4'b1001: w_cond_ex = ~r_flags[1] | r_flags[2];
            4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
            default: w_cond_ex = 1'b1;
        endcase
    end

    always_comb begin
        case (w_funct[4:1])
            4'b0100: w_dp_op = c_op_add;
            4'b0010: w_dp_op = c_op_sub;
            4'b0000: w_dp_op = c_op_and;
            4'b1100: w_dp_op = c_op_orr;
            4'b0001: w_dp_op = c_op_eor;
            default: w_dp_op = c_op_add;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_fetch:    if (w_mem_ready) w_next = c_decode;
            c_decode: begin
                case (w_op)
                    2'b01:   w_next = c_memadr;
                    2'b00:   w_next = w_funct[5] ? c_execi : c_execr;
                    2'b10:   w_next = c_branch;
                    default: w_next = c_undef;
                endcase
            end
            c_memadr:   w_next = w_funct[0] ? c_memread : c_memwrite;
            c_memread:  if (w_mem_ready) w_next = c_memwb;
            c_memwrite: if (w_mem_ready) w_next = c_fetch;
            c_execr,
            c_execi:    w_next = c_aluwb;
            default:    w_next = c_fetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_fetch;
            r_flags   <= 4'b0000;
            r_cond_ex <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == c_decode)
                r_cond_ex <= w_cond_ex;
            // Logical ops leave carry/overflow untouched
            if ((r_state == c_execr || r_state == c_execi) && r_cond_ex && w_funct[0]) begin
                r_flags[3:2] <= bus.ALUFlags[3:2];
                if (w_dp_op == c_op_add || w_dp_op == c_op_sub)
                    r_flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'd0;
        w_result_src = 2'd0;
        w_alu_ctrl   = c_op_add;
        w_state_out  = r_state;
        if (!reset) begin
            w_state_out  = c_fetch;
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = 2'd2;
            w_result_src = 2'd2;
        end else begin
            case (r_state)
                c_fetch: begin
                    w_ir_write   = w_mem_ready;
                    w_pc_write   = w_mem_ready;
                    w_alu_src_a  = 1'b1;
                    w_alu_src_b  = 2'd2;
                    w_result_src = 2'd2;
                end
                c_decode: begin
                    w_alu_src_a  = 1'b1;
                    w_alu_src_b  = 2'd2;
                    w_result_src = 2'd2;
                end
                c_memadr:   w_alu_src_b = 2'd1;
                c_memread:  w_adr_src   = 1'b1;
                c_memwb: begin
                    w_result_src = 2'd1;
                    w_reg_write  = r_cond_ex;
                    w_pc_write   = r_cond_ex & w_rd_pc;
                end
                c_memwrite: begin
                    w_adr_src   = 1'b1;
                    w_mem_write = r_cond_ex;
                end
                c_execr: begin
                    w_alu_src_b = 2'd0;
                    w_alu_ctrl  = w_dp_op;
                end
                c_execi: begin
                    w_alu_src_b = 2'd1;
                    w_alu_ctrl  = w_dp_op;
                end
                c_aluwb: begin
                    w_result_src = 2'd0;
                    w_reg_write  = r_cond_ex;
                    w_pc_write   = r_cond_ex & w_rd_pc;
                end
                c_branch: begin
                    w_alu_src_a  = 1'b0;
                    w_alu_src_b  = 2'd1;
                    w_result_src = 2'd2;
                    w_pc_write   = r_cond_ex;
                end
                default: ;
            endcase
        end
    end

    assign bus.PCWrite    = w_pc_write;
    assign bus.IRWrite    = w_ir_write;
    assign bus.RegWrite   = w_reg_write;
    assign bus.MemWrite   = w_mem_write;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUControl = w_alu_ctrl;
    assign bus.State      = w_state_out;
    assign bus.ImmSrc     = w_op;
    assign bus.RegSrc     = {w_op == 2'b01, w_op == 2'b10};

endmodule
`default_nettype wire
